ps2_key_serializer: RTL and testbench
=====================================

// Module: ps2_key_serializer
// PURPOSE
//  Converts mist_io's parallel ps2_key event word into a genuine PS/2 device byte stream for the MSX core's PS/2 keyboard input.
//  Adds E0/F0 prefixes, buffers the bytes in a FIFO, and serializes 11-bit frames with odd parity.
//  Honours host clock-inhibit from the core: an aborted byte is retransmitted.
//  Sits between mist_io (ps2_key) and Mister_top (ps2_clk_i/ps2_data_i).
// PARAMETERS
//  CLK_DIV     750   clk_sys cycles per PS2 clock half-period (21.477MHz -> ~14.3kHz)
//  GAP_CYC     1500  idle cycles, lines high, after each frame or inhibit release
//  FIFO_AW     4     FIFO address width; depth = 2**FIFO_AW bytes
// PORTS
//  clk_sys     in   1   system clock (21.477MHz)
//  reset_n     in   1   async active-low reset
//  ps2_key     in   11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode
//  host_clk_i  in   1   host-side PS2 clock, async; 0 = host inhibit
//  ps2_clk_o   out  1   PS2 clock to core (idle 1)
//  ps2_data_o  out  1   PS2 data to core (idle 1)
//  busy_o      out  1   1 while a frame/gap is in progress or FIFO non-empty
//  overflow_o  out  1   1-cycle pulse when an event is dropped
// BEHAVIOUR
//  Reset (async): ps2_clk_o=1, ps2_data_o=1, busy_o=0, overflow_o=0; FIFO empty; encoder/serializer IDLE.
//  First clk after reset_n release: prev_toggle<=ps2_key[10]; no event generated.
//  Encoder FSM IDLE/E0/F0/CODE: in IDLE, ps2_key[10]!=prev_toggle -> latch key, prev_toggle<=ps2_key[10].
//   Needed = 1 + ext + !pressed. If free slots < needed: drop event, overflow_o=1 next cycle, stay IDLE.
//   Otherwise push one byte per cycle: 0xE0 if ext, then 0xF0 if release, then the code; then IDLE.
//   A toggle arriving while not IDLE is detected on return to IDLE; later toggles since then are merged, with the latest key winning.
//  Push and pop may occur in the same cycle; the count is unchanged.
//  host_clk_i passes through a 2-FF synchronizer (hsync), reset value 1.
//  Serializer FSM IDLE/HIGH/LOW/GAP; the byte is peeked at the FIFO head and popped only after the stop bit completes.
//   IDLE: FIFO non-empty & hsync=1 -> next clk ps2_data_o=bit0 (start=0), state HIGH, bit=0.
//   HIGH: clk_o=1 for CLK_DIV cycles, data=frame[bit]; then LOW: clk_o=0 for CLK_DIV cycles.
//   After LOW: bit<10 -> bit+1, HIGH with new data; bit==10 -> pop, GAP.
//   frame = {stop=1, parity=~^code, code[7:0], start=0}, sent LSB first.
//   GAP: lines high for GAP_CYC cycles, then IDLE.
//   A new frame starts only in IDLE, so back-to-back frames are spaced 2*CLK_DIV*11+GAP_CYC cycles.
//  Inhibit: hsync=0 during HIGH with bit<10 -> next clk clk_o=1, data_o=1, no pop.
//   Wait for hsync=1, then GAP, then resend the same byte from the start bit.
//   hsync=0 during LOW, or at bit==10, is ignored; the frame completes.
//   hsync=0 in IDLE blocks the start; hsync=0 in GAP restarts the GAP count after release.
//  Counters are $clog2 sized and wrap only via explicit reload. The FIFO count is FIFO_AW+1 bits, so 2**FIFO_AW means full.
//  busy_o = (state!=IDLE) | (count!=0) | (enc!=IDLE).
//  reset_n asserted mid-frame: lines return to 1 immediately (async); the FIFO is flushed.
// TESTING
//  Reset: reset_n=0 -> clk_o=1, data_o=1, busy_o=0. Release with ps2_key[10]=1 -> no frame within 5000 cycles.
//  Make code: toggle, pressed, code 0x1C -> one frame; data on LOW edges = 0,0,0,1,1,1,0,0,0,0,1 (parity 0); each half = 750 cycles.
//  Extended release code 0x75 -> three frames E0, F0, 75; parity 0,1,0; inter-frame gap = 1500 cycles high.
//  Overflow: FIFO_AW=2, host_clk_i=0 held, make 0x1C x4 -> 4 bytes queued, 5th -> overflow_o pulse. Release host -> exactly 4 frames of 0x1C.
//  Inhibit: code 0x00 (parity 1), host_clk_i=0 during HIGH of bit 5 -> lines high, no pop. Release -> gap, then full 0x00 frame resent once.
//  Reset mid-frame: reset_n=0 at bit 4 -> lines=1 asynchronously. After release, FIFO empty and no further frames.

Source files
------------

// File: rtl/ps2_key_serializer_if.sv
// ps2_key_serializer_if: key-event input and PS/2 device-side lines of ps2_key_serializer
//   ps2_key    [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   host_clk_i host-side PS/2 clock (async), 0 = host inhibit
//   ps2_clk_o  PS/2 clock towards the core, idle 1
//   ps2_data_o PS/2 data towards the core, idle 1
//   busy_o     frame/gap in progress, encoder active or FIFO non-empty
//   overflow_o one-cycle pulse when a key event is dropped
interface ps2_key_serializer_if;
  logic [10:0] ps2_key;
  logic        host_clk_i;
  logic        ps2_clk_o;
  logic        ps2_data_o;
  logic        busy_o;
  logic        overflow_o;
  modport master (input ps2_key, host_clk_i, output ps2_clk_o, ps2_data_o, busy_o, overflow_o);
  modport slave  (output ps2_key, host_clk_i, input ps2_clk_o, ps2_data_o, busy_o, overflow_o);
endinterface

// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: turns mist_io ps2_key events into a PS/2 device byte stream with E0/F0 prefixes
//   clk_sys  system clock
//   reset_n  async active-low reset
//   bus      ps2_key_serializer_if.master (ps2_key, host_clk_i in; ps2_clk_o, ps2_data_o, busy_o, overflow_o out)
module ps2_key_serializer #(
  parameter int CLK_DIV = 750,
  parameter int GAP_CYC = 1500,
  parameter int FIFO_AW = 4
) (
  input logic                  clk_sys,
  input logic                  reset_n,
  ps2_key_serializer_if.master bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = $clog2((CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC) + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
  localparam logic [1:0] E_IDLE = 2'd0, E_E0 = 2'd1, E_F0 = 2'd2, E_CODE = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2, S_GAP = 2'd3;
  logic [1:0]         enc;
  logic               armed;
  logic               prev_toggle;
  logic               key_rel;
  logic [7:0]         key_code;
  logic               ovf;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   free;
  logic [1:0]         need;
  logic               toggle_ev;
  logic               push;
  logic               pop;
  logic [7:0]         push_data;
  logic [7:0]         head;
  logic [10:0]        frame;
  logic [1:0]         hs;
  logic               hsync;
  logic [1:0]         ser;
  logic [CW-1:0]      cnt;
  logic [3:0]         bitn;
  logic               clk_o;
  logic               data_o;
  // armed stays low for the first clock after reset so the current toggle level is only sampled
  assign toggle_ev = armed && (bus.ps2_key[10] != prev_toggle);
  assign need = 2'd1 + {1'b0, bus.ps2_key[8]} + {1'b0, ~bus.ps2_key[9]};
  assign free = (FIFO_AW + 1)'(DEPTH) - count;
  assign push = enc != E_IDLE;
  assign push_data = enc == E_E0 ? 8'hE0 : enc == E_F0 ? 8'hF0 : key_code;
  assign head = mem[rptr];
  assign frame = {1'b1, ~^head, head, 1'b0};
  assign hsync = hs[1];
  assign pop = ser == S_LOW && cnt == '0 && bitn == 4'd10;
  assign bus.ps2_clk_o = clk_o;
  assign bus.ps2_data_o = data_o;
  assign bus.overflow_o = ovf;
  assign bus.busy_o = (ser != S_IDLE) | (count != '0) | (enc != E_IDLE);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      enc <= E_IDLE;
      armed <= 1'b0;
      prev_toggle <= 1'b0;
      key_rel <= 1'b0;
      key_code <= 8'h00;
      ovf <= 1'b0;
    end else begin
      armed <= 1'b1;
      ovf <= 1'b0;
      if (!armed) prev_toggle <= bus.ps2_key[10];
      if (enc == E_IDLE && toggle_ev) begin
        prev_toggle <= bus.ps2_key[10];
        key_rel <= ~bus.ps2_key[9];
        key_code <= bus.ps2_key[7:0];
        // the whole sequence is reserved up front so a key never goes out half-prefixed
        if (free < (FIFO_AW + 1)'(need)) ovf <= 1'b1;
        else enc <= bus.ps2_key[8] ? E_E0 : ~bus.ps2_key[9] ? E_F0 : E_CODE;
      end else if (enc == E_E0) enc <= key_rel ? E_F0 : E_CODE;
      else if (enc == E_F0) enc <= E_CODE;
      else if (enc == E_CODE) enc <= E_IDLE;
    end
  always_ff @(posedge clk_sys)
    if (push) mem[wptr] <= push_data;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop) rptr <= rptr + FIFO_AW'(1);
      count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) hs <= 2'b11;
    else hs <= {hs[0], bus.host_clk_i};
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      ser <= S_IDLE;
      cnt <= '0;
      bitn <= 4'd0;
      clk_o <= 1'b1;
      data_o <= 1'b1;
    end else if (ser == S_IDLE) begin
      if (count != '0 && hsync) begin
        ser <= S_HIGH;
        bitn <= 4'd0;
        cnt <= HALF_LD;
        data_o <= frame[0];
      end
    end else if (ser == S_HIGH) begin
      // an inhibit aborts the byte without popping it; the GAP state waits out the inhibit
      if (!hsync && bitn != 4'd10) begin
        ser <= S_GAP;
        cnt <= GAP_LD;
        data_o <= 1'b1;
      end else if (cnt == '0) begin
        ser <= S_LOW;
        cnt <= HALF_LD;
        clk_o <= 1'b0;
      end else cnt <= cnt - CW'(1);
    end else if (ser == S_LOW) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      else if (bitn == 4'd10) begin
        ser <= S_GAP;
        cnt <= GAP_LD;
        clk_o <= 1'b1;
        data_o <= 1'b1;
      end else begin
        ser <= S_HIGH;
        bitn <= bitn + 4'd1;
        cnt <= HALF_LD;
        clk_o <= 1'b1;
        data_o <= frame[bitn + 4'd1];
      end
    end else begin
      if (!hsync) cnt <= GAP_LD;
      else if (cnt == '0) ser <= S_IDLE;
      else cnt <= cnt - CW'(1);
    end
endmodule

// File: tb/tb_ps2_key_serializer.sv
// tb_ps2_key_serializer: scoreboard bench decoding PS/2 frames off the serializer lines
module tb_ps2_key_serializer;
  localparam int CLK_DIV = 10;
  localparam int GAP_CYC = 30;
  localparam int FIFO_AW = 2;
  localparam int FRAME_CYC = 22 * CLK_DIV + GAP_CYC + 2;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  ps2_key_serializer_if bus();
  ps2_key_serializer #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .FIFO_AW(FIFO_AW)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  int checks = 0;
  int failures = 0;
  logic [10:0] sb[$];
  int frames = 0;
  int aborts = 0;
  int falls = 0;
  int ovf_cyc = 0;
  int cyc = 0;
  int rise_t = 0;
  int last_gap = -1;
  int hi = 0;
  int lo = 0;
  int nb = 0;
  logic pc = 1'b1;
  logic pd = 1'b1;
  logic [10:0] sh = '0;
  logic tg = 1'b1;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask
  // monitor: rebuilds frames from the lines and pops the scoreboard on each complete frame
  always @(negedge clk_sys) begin
    cyc++;
    if (bus.overflow_o) ovf_cyc++;
    if (!reset_n) begin
      nb = 0;
      hi = 0;
      lo = 0;
      pc = 1'b1;
      pd = 1'b1;
      rise_t = 0;
    end else begin
      if (pc && !bus.ps2_clk_o) begin
        falls++;
        chk("high_half", hi, CLK_DIV);
        sh[nb] = bus.ps2_data_o;
        nb++;
        if (nb == 11) begin
          frames++;
          nb = 0;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame got=0x%0h expected=none", sh);
          end else chk("frame", int'(sh), int'(sb.pop_front()));
        end
      end
      if (!pc && bus.ps2_clk_o) begin
        chk("low_half", lo, CLK_DIV);
        rise_t = cyc;
      end
      if (pc && bus.ps2_clk_o && pd && !bus.ps2_data_o && rise_t > 0) begin
        last_gap = cyc - rise_t;
        checks++;
        if (last_gap < GAP_CYC) begin
          failures++;
          $display("FAIL min_gap got=%0d expected>=%0d", last_gap, GAP_CYC);
        end
      end
      if (!bus.ps2_clk_o) begin
        lo = pc ? 1 : lo + 1;
        hi = 0;
      end else hi = (!pc || (pd && !bus.ps2_data_o)) ? 1 : hi + 1;
      if (bus.ps2_clk_o && nb > 0 && hi > CLK_DIV) begin
        nb = 0;
        aborts++;
      end
      pc = bus.ps2_clk_o;
      pd = bus.ps2_data_o;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask
  task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
    tg = ~tg;
    bus.ps2_key = {tg, pressed, ext, code};
    tick(6);
  endtask
  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.busy_o) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain got=pending:%0d busy:%0b expected=empty,idle", name, sb.size(), bus.busy_o);
    end
  endtask
  task automatic wait_falls(input string name, input int target);
    int n = 0;
    while (falls < target && n < 4 * FRAME_CYC) begin
      tick(1);
      n++;
    end
    chk({name, "_edges"}, falls, target);
  endtask
  initial begin
    int f0;
    int o0;
    int a0;
    bus.ps2_key = {1'b1, 10'd0};
    bus.host_clk_i = 1'b1;
    #23;
    chk("rst_clk", bus.ps2_clk_o, 1);
    chk("rst_data", bus.ps2_data_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);
    tick(1);
    reset_n = 1'b1;
    tick(5000);
    chk("no_frame_after_reset", frames, 0);
    chk("idle_after_reset", bus.busy_o, 0);
    sb.push_back({1'b1, 1'b0, 8'h1C, 1'b0});
    key(1'b1, 1'b0, 8'h1C);
    drain("make_1c", 2 * FRAME_CYC);
    chk("make_frames", frames, 1);
    sb.push_back({1'b1, 1'b0, 8'hE0, 1'b0});
    sb.push_back({1'b1, 1'b1, 8'hF0, 1'b0});
    sb.push_back({1'b1, 1'b0, 8'h75, 1'b0});
    key(1'b0, 1'b1, 8'h75);
    drain("ext_rel_75", 4 * FRAME_CYC);
    chk("ext_frames", frames, 4);
    chk("ext_gap_in_range", int'(last_gap >= GAP_CYC && last_gap <= GAP_CYC + 1), 1);
    bus.host_clk_i = 1'b0;
    tick(5);
    o0 = ovf_cyc;
    f0 = frames;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({1'b1, 1'b0, 8'h1C, 1'b0});
      key(1'b1, 1'b0, 8'h1C);
    end
    chk("no_ovf_when_fits", ovf_cyc, o0);
    key(1'b1, 1'b0, 8'h1C);
    chk("ovf_pulse", ovf_cyc, o0 + 1);
    chk("held_no_frames", frames, f0);
    chk("held_busy", bus.busy_o, 1);
    bus.host_clk_i = 1'b1;
    drain("ovf_release", 6 * FRAME_CYC);
    chk("ovf_frames", frames, f0 + 4);
    f0 = frames;
    a0 = aborts;
    sb.push_back({1'b1, 1'b1, 8'h00, 1'b0});
    key(1'b1, 1'b0, 8'h00);
    wait_falls("inh", falls + 5);
    while (!bus.ps2_clk_o) tick(1);
    tick(2);
    bus.host_clk_i = 1'b0;
    tick(20);
    chk("inh_clk_high", bus.ps2_clk_o, 1);
    chk("inh_data_high", bus.ps2_data_o, 1);
    chk("inh_busy", bus.busy_o, 1);
    bus.host_clk_i = 1'b1;
    drain("inhibit", 3 * FRAME_CYC);
    chk("inh_aborts", aborts, a0 + 1);
    chk("inh_resent_once", frames, f0 + 1);
    f0 = frames;
    sb.push_back({1'b1, 1'b1, 8'h24, 1'b0});
    key(1'b1, 1'b0, 8'h24);
    wait_falls("rst_mid", falls + 5);
    tick(2);
    #2;
    chk("pre_rst_clk_low", bus.ps2_clk_o, 0);
    chk("pre_rst_data_bit4", bus.ps2_data_o, 0);
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_clk", bus.ps2_clk_o, 1);
    chk("async_rst_data", bus.ps2_data_o, 1);
    tick(3);
    reset_n = 1'b1;
    tick(1000);
    chk("flushed_no_frames", frames, f0);
    chk("flushed_idle", bus.busy_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
